// File: rtl/lut_ram_multiport_pkg.sv
// Shared types and helpers for the multi-port LUT RAM.
// The init sequencer state type and the depth computation live here.
package lut_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/lut_ram_multiport_if.sv
// Bus interface for lut_ram_multiport: write port, NUM_RD packed read ports, status.
// The master drives requests and the slave (the RAM) returns data and status.
interface lut_ram_multiport_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
);
    logic                     init_done;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr_dropped;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  init_done, rd_data, rd_valid, wr_dropped
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output init_done, rd_data, rd_valid, wr_dropped
    );

endinterface

// File: rtl/lut_ram_multiport_init_seq.sv
// Init sequencer: fills every entry with INIT_WORD after reset, then hands the
// array write port to the user. Flags user writes that arrive during the fill.
//
//   state | meaning
//   INIT  | sweeping addresses 0..DEPTH-1, writing INIT_WORD; user writes dropped
//   READY | array initialised; user write port passed through
module lut_ram_init_seq
    import lut_ram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_init_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_wr_drop
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_init_done;
    logic              w_init_done_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        o_mem_we        = i_wr_en;
        o_mem_addr      = i_wr_addr;
        o_mem_data      = i_wr_data;
        o_wr_drop       = 1'b0;
        case (r_state)
            INIT: begin
                o_mem_we   = 1'b1;
                o_mem_addr = r_cnt;
                o_mem_data = INIT_WORD;
                o_wr_drop  = i_wr_en;
                w_cnt_nxt  = r_cnt + 1'b1;
                // Last address written this cycle: done is visible from the next edge.
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt     = READY;
                    w_init_done_nxt = 1'b1;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign o_init_done = r_init_done;

endmodule

// File: rtl/lut_ram_multiport.sv
// Distributed RAM with one write port and NUM_RD read ports, self-initialised to INIT_WORD.
// Define LUT_RAM_WR_BYPASS_EN for write-first reads; default is read-first.
module lut_ram_multiport
    import lut_ram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 5,
    parameter int                NUM_RD    = 3,
    parameter int                OUT_REG   = 1,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    lut_ram_multiport_if.slave  bus
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_init_done;
    logic              w_wr_drop;
    logic              r_wr_dropped;
    logic [DATA_W-1:0] w_rd_word [NUM_RD];

    lut_ram_init_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_WORD (INIT_WORD)
    ) u_init_seq (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_wr_en     (bus.wr_en),
        .i_wr_addr   (bus.wr_addr),
        .i_wr_data   (bus.wr_data),
        .o_init_done (w_init_done),
        .o_mem_we    (w_mem_we),
        .o_mem_addr  (w_mem_addr),
        .o_mem_data  (w_mem_data),
        .o_wr_drop   (w_wr_drop)
    );

    // No reset on the array: it maps to LUT RAM, which is cleared by the sequencer instead.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_dropped <= 1'b0;
        end else if (w_wr_drop) begin
            r_wr_dropped <= 1'b1;
        end
    end

    assign bus.init_done  = w_init_done;
    assign bus.wr_dropped = r_wr_dropped;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = bus.rd_addr[g*ADDR_W +: ADDR_W];

`ifdef LUT_RAM_WR_BYPASS_EN
        assign w_rd_word[g] = (bus.wr_en && w_init_done && (bus.wr_addr == w_addr))
                              ? bus.wr_data : r_mem[w_addr];
`else
        assign w_rd_word[g] = r_mem[w_addr];
`endif

        if (OUT_REG != 0) begin : g_reg
            logic [DATA_W-1:0] r_data;
            logic              r_valid;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= bus.rd_en[g] & w_init_done;
                    if (bus.rd_en[g] && w_init_done) begin
                        r_data <= w_rd_word[g];
                    end
                end
            end

            assign bus.rd_data[g*DATA_W +: DATA_W] = r_data;
            assign bus.rd_valid[g]                 = r_valid;
        end else begin : g_comb
            assign bus.rd_data[g*DATA_W +: DATA_W] = w_rd_word[g];
            assign bus.rd_valid[g]                 = bus.rd_en[g] & w_init_done;
        end
    end

endmodule
